// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, range helper
// and a generic binary-to-Gray conversion.
package gray_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   function automatic longint unsigned max_count(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder; inverse of the downstream
// Gray-to-binary decoder stage.
module bin_to_gray
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load, wrap or
// saturate at the range ends, terminal-count and change strobes.
module gray_counter
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned WRAP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] g,
   output logic             tc,
   output logic             chg
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] g_next;
   logic             tc_next;
   logic             chg_next;

   // Next binary count with load > enable > hold priority; Gray and bin only
   // ever change together, so a load changes g exactly when d differs from bin.
   always_comb begin
      bin_next = bin;
      tc_next  = 1'b0;
      chg_next = 1'b0;
      if (load) begin
         bin_next = d;
         chg_next = (d != bin);
      end else if (en) begin
         if (up) begin
            if (bin != MAX) begin
               bin_next = bin + 1'b1;
               chg_next = 1'b1;
            end else begin
               tc_next = 1'b1;
               if (WRAP != 0) begin
                  bin_next = '0;
                  chg_next = 1'b1;
               end
            end
         end else begin
            if (bin != '0) begin
               bin_next = bin - 1'b1;
               chg_next = 1'b1;
            end else begin
               tc_next = 1'b1;
               if (WRAP != 0) begin
                  bin_next = MAX;
                  chg_next = 1'b1;
               end
            end
         end
      end
   end

   bin_to_gray #(
      .WIDTH (WIDTH)
   ) u_enc (
      .bin  (bin_next),
      .gray (g_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin <= '0;
         g   <= '0;
         tc  <= 1'b0;
         chg <= 1'b0;
      end else begin
         bin <= bin_next;
         g   <= g_next;
         tc  <= tc_next;
         chg <= chg_next;
      end
   end

endmodule
